// File: rtl/crt_pkg.sv
// Shared types and decode tables for the CRT row fetch engine.
package crt_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_GAP,
    ST_DONE,
    ST_STOP
  } fill_state_e;

  // In-band control bytes carried on the DMA stream; never stored.
  localparam logic [7:0] END_ROW    = 8'hF1;
  localparam logic [7:0] END_SCREEN = 8'hF3;

  // burst_len code -> bytes per burst (index 0 is the rightmost entry).
  localparam logic [3:0][3:0] BURST_TBL = {4'd8, 4'd4, 4'd2, 4'd1};

  // burst_gap code -> ce pulses to idle between bursts.
  localparam logic [7:0][5:0] GAP_TBL =
    {6'd55, 6'd47, 6'd39, 6'd31, 6'd23, 6'd15, 6'd7, 6'd0};

endpackage

// File: rtl/crt_row_bank.sv
// Double-buffered row storage: one bank is filled while the other is shown.
module crt_row_bank #(
  parameter int COLS = 80,
  parameter int AW   = 7
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          we,
  input  logic          wr_sel,
  input  logic [AW-1:0] wr_addr,
  input  logic [7:0]    wr_data,
  input  logic          rd_sel,
  input  logic [AW-1:0] rd_addr,
  input  logic          rd_blank,
  output logic [7:0]    rd_data
);

  localparam logic [AW:0] COLS_W = (AW+1)'(COLS);

  logic [7:0] mem_q [2][COLS];
  logic [7:0] rd_data_q;

  // RAM write port; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (we && ({1'b0, wr_addr} < COLS_W)) begin
      mem_q[wr_sel][wr_addr] <= wr_data;
    end
  end

  // Registered read; columns past the stored row length read as blank.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_data_q <= 8'h00;
    end else if (rd_blank || ({1'b0, rd_addr} >= COLS_W)) begin
      rd_data_q <= 8'h00;
    end else begin
      rd_data_q <= mem_q[rd_sel][rd_addr];
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/crt_row_fetch.sv
// CRT character-row DMA fetcher: bursts bytes into a fill bank while the
// display side reads the other bank, swapping at each row boundary.
module crt_row_fetch
  import crt_pkg::*;
#(
  parameter int COLS = 80,
  parameter int AW   = 7
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          ce,
  input  logic          enable,
  input  logic [AW-1:0] max_col,
  input  logic [1:0]    burst_len,
  input  logic [2:0]    burst_gap,
  input  logic          frame_start,
  input  logic          row_swap,
  output logic          drq,
  input  logic          dack,
  input  logic [7:0]    ichar,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    rd_data,
  output logic          underrun,
  input  logic          clr_status,
  output logic          stopped
);

  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  fill_state_e     state_q, state_d;
  logic            drq_q;
  logic [AW:0]     wr_ptr_q, wr_ptr_d;
  logic [3:0]      burst_q, burst_d;
  logic [5:0]      gap_q, gap_d;
  logic            fill_sel_q, fill_sel_d;
  logic [1:0][AW:0] row_len_q, row_len_d;
  logic            underrun_q, underrun_d;
  logic            stopped_q, stopped_d;

  logic            accept, we, fill_open, underrun_set;
  logic [AW:0]     row_end;
  logic [5:0]      gap_len;
  logic [3:0]      burst_size;
  logic            rd_blank;

  assign row_end    = {1'b0, max_col} + PTR_ONE;
  assign gap_len    = GAP_TBL[burst_gap];
  assign burst_size = BURST_TBL[burst_len];
  assign rd_blank   = {1'b0, rd_addr} >= row_len_q[~fill_sel_q];

  // Next-state: byte acceptance and gap timing first, then enable,
  // row_swap and frame_start overrides in increasing priority.
  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    burst_d      = burst_q;
    gap_d        = gap_q;
    fill_sel_d   = fill_sel_q;
    row_len_d    = row_len_q;
    stopped_d    = stopped_q;
    underrun_set = 1'b0;
    accept       = drq_q && dack;
    we           = 1'b0;

    case (state_q)
      ST_REQ: begin
        if (wr_ptr_q >= row_end) begin
          // max_col shrank below what is already stored
          state_d              = ST_DONE;
          row_len_d[fill_sel_q] = row_end;
        end else if (accept) begin
          if (ichar == END_ROW) begin
            row_len_d[fill_sel_q] = wr_ptr_q;
            state_d               = ST_DONE;
          end else if (ichar == END_SCREEN) begin
            row_len_d[fill_sel_q] = wr_ptr_q;
            state_d               = ST_STOP;
            stopped_d             = 1'b1;
          end else begin
            we       = 1'b1;
            wr_ptr_d = wr_ptr_q + PTR_ONE;
            if (wr_ptr_q == {1'b0, max_col}) begin
              state_d               = ST_DONE;
              row_len_d[fill_sel_q] = row_end;
              burst_d               = 4'd0;
            end else if (burst_q + 4'd1 == burst_size) begin
              state_d = ST_GAP;
              burst_d = 4'd0;
              gap_d   = 6'd0;
            end else begin
              burst_d = burst_q + 4'd1;
            end
          end
        end
      end
      ST_GAP: begin
        if (gap_len == 6'd0) begin
          state_d = ST_REQ;
        end else if (ce) begin
          if (gap_q + 6'd1 == gap_len) begin
            state_d = ST_REQ;
            gap_d   = 6'd0;
          end else begin
            gap_d = gap_q + 6'd1;
          end
        end
      end
      default: ;
    endcase

    fill_open = (state_d == ST_REQ) || (state_d == ST_GAP);

    if (!enable) begin
      state_d = ST_IDLE;
    end

    if (frame_start) begin
      stopped_d = 1'b0;
      row_len_d = '0;
      wr_ptr_d  = '0;
      burst_d   = 4'd0;
      gap_d     = 6'd0;
      state_d   = enable ? ST_REQ : ST_IDLE;
    end else if (row_swap) begin
      if (fill_open) begin
        // show whatever made it in, including a byte taken this clk
        underrun_set          = 1'b1;
        row_len_d[fill_sel_q] = wr_ptr_d;
      end
      fill_sel_d = ~fill_sel_q;
      wr_ptr_d   = '0;
      burst_d    = 4'd0;
      gap_d      = 6'd0;
      if (!enable) begin
        state_d = ST_IDLE;
      end else if (stopped_d) begin
        state_d = ST_STOP;
      end else begin
        state_d = ST_REQ;
      end
      if (stopped_d) begin
        row_len_d[~fill_sel_q] = '0;
      end
    end

    underrun_d = underrun_set || (underrun_q && !clr_status);
  end

  // Control and status registers; drq is registered from the next state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      drq_q      <= 1'b0;
      wr_ptr_q   <= '0;
      burst_q    <= 4'd0;
      gap_q      <= 6'd0;
      fill_sel_q <= 1'b0;
      row_len_q  <= '0;
      underrun_q <= 1'b0;
      stopped_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      drq_q      <= (state_d == ST_REQ);
      wr_ptr_q   <= wr_ptr_d;
      burst_q    <= burst_d;
      gap_q      <= gap_d;
      fill_sel_q <= fill_sel_d;
      row_len_q  <= row_len_d;
      underrun_q <= underrun_d;
      stopped_q  <= stopped_d;
    end
  end

  crt_row_bank #(
    .COLS (COLS),
    .AW   (AW)
  ) u_bank (
    .clk      (clk),
    .reset_n  (reset_n),
    .we       (we),
    .wr_sel   (fill_sel_q),
    .wr_addr  (wr_ptr_q[AW-1:0]),
    .wr_data  (ichar),
    .rd_sel   (~fill_sel_q),
    .rd_addr  (rd_addr),
    .rd_blank (rd_blank),
    .rd_data  (rd_data)
  );

  assign drq      = drq_q;
  assign underrun = underrun_q;
  assign stopped  = stopped_q;

endmodule

// File: tb/tb_crt_row_fetch.sv
// Randomized bench for crt_row_fetch: a DMA-side driver records what was
// handed over, and expectations come from the row/burst/gap rules directly.
module tb_crt_row_fetch;

  localparam int COLS = 80;
  localparam int AW   = 7;

  logic          clk = 1'b0;
  logic          reset_n, ce, enable, frame_start, row_swap, dack, clr_status;
  logic [AW-1:0] max_col, rd_addr;
  logic [1:0]    burst_len;
  logic [2:0]    burst_gap;
  logic [7:0]    ichar, rd_data;
  logic          drq, underrun, stopped;

  int total = 0;
  int bad   = 0;

  logic [7:0] src_q[$];
  logic [7:0] acc_q[$];
  int         burst_q[$];
  int         gap_ce_q[$];
  int         gap_cyc_q[$];
  int         pulses;
  bit         timed_out;

  always #5 clk = ~clk;

  crt_row_fetch #(.COLS(COLS), .AW(AW)) dut (
    .clk(clk), .reset_n(reset_n), .ce(ce), .enable(enable), .max_col(max_col),
    .burst_len(burst_len), .burst_gap(burst_gap), .frame_start(frame_start),
    .row_swap(row_swap), .drq(drq), .dack(dack), .ichar(ichar),
    .rd_addr(rd_addr), .rd_data(rd_data), .underrun(underrun),
    .clr_status(clr_status), .stopped(stopped)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_frame();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  task automatic pulse_swap();
    row_swap = 1'b1;
    tick();
    row_swap = 1'b0;
  endtask

  task automatic pulse_clr();
    clr_status = 1'b1;
    tick();
    clr_status = 1'b0;
  endtask

  task automatic read_col(input int a, output logic [7:0] v);
    rd_addr = AW'(a);
    tick();
    v = rd_data;
  endtask

  function automatic logic [7:0] rnd_byte();
    logic [7:0] b;
    b = 8'($urandom_range(255));
    if (b == 8'hF1 || b == 8'hF3) b = 8'h5A;
    return b;
  endfunction

  // DMA peer: serves src_q in order, logs bursts and the ce count of each gap.
  task automatic dma_run(input int stop_after, input int max_cyc,
                         input int dack_pct, input int ce_pct);
    int n_acc = 0, cur = 0, gce = 0, gcyc = 0;
    bit in_pulse = 0, seen = 0, d;
    acc_q.delete(); burst_q.delete(); gap_ce_q.delete(); gap_cyc_q.delete();
    pulses = 0;
    for (int c = 0; c < max_cyc && n_acc < stop_after; c++) begin
      d  = drq;
      ce = ($urandom_range(99) < ce_pct);
      if (d) dack = ($urandom_range(99) < dack_pct);
      else   dack = 1'($urandom_range(1));
      ichar = (n_acc < src_q.size()) ? src_q[n_acc] : 8'h00;
      if (d) begin
        if (!in_pulse) begin
          pulses++;
          if (seen) begin gap_ce_q.push_back(gce); gap_cyc_q.push_back(gcyc); end
          in_pulse = 1; cur = 0;
        end
        if (dack) begin acc_q.push_back(ichar); cur++; n_acc++; end
      end else begin
        if (in_pulse) begin
          burst_q.push_back(cur); in_pulse = 0; seen = 1; gce = 0; gcyc = 0;
        end
        gce += int'(ce);
        gcyc++;
      end
      tick();
    end
    dack = 1'b0;
    ce   = 1'b0;
    if (in_pulse) burst_q.push_back(cur);
    timed_out = (n_acc < stop_after);
  endtask

  task automatic test_reset();
    reset_n = 1'b0; enable = 1'b1; dack = 1'b1; ce = 1'b1;
    frame_start = 1'b0; row_swap = 1'b0; clr_status = 1'b0;
    max_col = AW'(9); burst_len = 2'd1; burst_gap = 3'd1;
    ichar = 8'h00; rd_addr = '0;
    repeat (3) @(posedge clk);
    #1;
    total++; if (drq !== 1'b0) begin bad++; $display("FAIL reset_drq got=%b want=0", drq); end
    total++; if (rd_data !== 8'h00) begin bad++; $display("FAIL reset_rd_data got=%h want=00", rd_data); end
    total++; if (underrun !== 1'b0) begin bad++; $display("FAIL reset_underrun got=%b want=0", underrun); end
    total++; if (stopped !== 1'b0) begin bad++; $display("FAIL reset_stopped got=%b want=0", stopped); end
    reset_n = 1'b1; dack = 1'b0; ce = 1'b0;
    repeat (3) tick();
    total++; if (drq !== 1'b0) begin bad++; $display("FAIL idle_wait_drq got=%b want=0", drq); end
  endtask

  task automatic test_burst_gap();
    int n, bl, gc, size, exp_p, gval, errs, hi, e, pct;
    logic [7:0] v, expv;
    for (int k = 0; k < 4; k++) begin
      if (k == 0) begin n = 10; bl = 1; gc = 1; pct = 100; end
      else begin
        n = $urandom_range(4, 25); bl = $urandom_range(0, 3);
        gc = $urandom_range(0, 7); pct = 60;
      end
      max_col = AW'(n - 1); burst_len = 2'(bl); burst_gap = 3'(gc);
      size  = 1 << bl;
      exp_p = (n + size - 1) / size;
      gval  = (gc == 0) ? 0 : gc * 8 - 1;
      src_q.delete();
      for (int i = 0; i < n; i++) src_q.push_back(rnd_byte());
      pulse_frame();
      dma_run(n, 8000, pct, 50);
      total++; if (timed_out) begin bad++; $display("FAIL fill_timeout cfg=%0d got=%0d want=%0d", k, acc_q.size(), n); end
      total++; if (pulses != exp_p) begin bad++; $display("FAIL drq_pulses cfg=%0d got=%0d want=%0d", k, pulses, exp_p); end
      errs = 0;
      if (burst_q.size() != exp_p) errs++;
      else for (int i = 0; i < exp_p; i++) begin
        e = (n - i * size < size) ? n - i * size : size;
        if (burst_q[i] != e) errs++;
      end
      total++; if (errs != 0) begin bad++; $display("FAIL burst_sizes cfg=%0d bad_bursts=%0d want=0", k, errs); end
      errs = 0;
      if (gap_ce_q.size() != exp_p - 1) errs++;
      else for (int i = 0; i < exp_p - 1; i++) begin
        if (gc == 0) begin if (gap_cyc_q[i] != 1) errs++; end
        else if (gap_ce_q[i] != gval) errs++;
      end
      total++; if (errs != 0) begin bad++; $display("FAIL gap_ce cfg=%0d bad_gaps=%0d want=0 (gap=%0d)", k, errs, gval); end
      hi = 0;
      for (int i = 0; i < 20; i++) begin ce = 1'($urandom_range(1)); dack = 1'b1; tick(); hi += int'(drq); end
      dack = 1'b0; ce = 1'b0;
      total++; if (hi != 0) begin bad++; $display("FAIL done_drq cfg=%0d high_cycles=%0d want=0", k, hi); end
      pulse_swap();
      total++; if (underrun !== 1'b0) begin bad++; $display("FAIL full_row_underrun cfg=%0d got=%b want=0", k, underrun); end
      for (int a = 0; a < n + 2; a++) begin
        read_col(a, v);
        expv = (a < n) ? src_q[a] : 8'h00;
        total++; if (v !== expv) begin bad++; $display("FAIL row_read cfg=%0d col=%0d got=%h want=%h", k, a, v, expv); end
      end
    end
  endtask

  task automatic test_end_row();
    int len;
    logic [7:0] v, expv;
    for (int k = 0; k < 2; k++) begin
      max_col = AW'(9); burst_len = 2'd3; burst_gap = 3'd0;
      src_q.delete();
      if (k == 0) begin src_q.push_back(8'h41); src_q.push_back(8'h42); len = 2; end
      else begin len = $urandom_range(0, 8); for (int i = 0; i < len; i++) src_q.push_back(rnd_byte()); end
      src_q.push_back(8'hF1);
      pulse_frame();
      dma_run(len + 1, 200, 100, 50);
      total++; if (drq !== 1'b0) begin bad++; $display("FAIL end_row_drq case=%0d got=%b want=0", k, drq); end
      pulse_swap();
      total++; if (underrun !== 1'b0) begin bad++; $display("FAIL end_row_underrun case=%0d got=%b want=0", k, underrun); end
      for (int a = 0; a < 10; a++) begin
        read_col(a, v);
        expv = (a < len) ? src_q[a] : 8'h00;
        total++; if (v !== expv) begin bad++; $display("FAIL end_row_read case=%0d col=%0d got=%h want=%h", k, a, v, expv); end
      end
    end
  endtask

  task automatic test_underrun();
    logic [7:0] v, expv;
    max_col = AW'(9); burst_len = 2'd1; burst_gap = 3'd0;
    src_q.delete();
    for (int i = 0; i < 10; i++) src_q.push_back(rnd_byte());
    pulse_frame();
    dma_run(4, 200, 100, 50);
    pulse_swap();
    total++; if (underrun !== 1'b1) begin bad++; $display("FAIL underrun_set got=%b want=1", underrun); end
    for (int a = 0; a < 10; a++) begin
      read_col(a, v);
      expv = (a < 4) ? src_q[a] : 8'h00;
      total++; if (v !== expv) begin bad++; $display("FAIL partial_read col=%0d got=%h want=%h", a, v, expv); end
    end
    pulse_clr();
    total++; if (underrun !== 1'b0) begin bad++; $display("FAIL underrun_clear got=%b want=0", underrun); end
    clr_status = 1'b1; row_swap = 1'b1;
    tick();
    clr_status = 1'b0; row_swap = 1'b0;
    total++; if (underrun !== 1'b1) begin bad++; $display("FAIL set_beats_clear got=%b want=1", underrun); end
  endtask

  task automatic test_end_screen();
    int hi = 0;
    logic [7:0] v, expv;
    pulse_clr();
    max_col = AW'(9); burst_len = 2'd3; burst_gap = 3'd0;
    src_q.delete();
    for (int i = 0; i < 3; i++) src_q.push_back(rnd_byte());
    src_q.push_back(8'hF3);
    pulse_frame();
    dma_run(4, 200, 100, 50);
    total++; if (stopped !== 1'b1) begin bad++; $display("FAIL stopped_set got=%b want=1", stopped); end
    for (int s = 0; s < 3; s++) begin
      pulse_swap();
      hi += int'(drq);
      if (s == 0) begin
        for (int a = 0; a < 5; a++) begin
          read_col(a, v); hi += int'(drq);
          expv = (a < 3) ? src_q[a] : 8'h00;
          total++; if (v !== expv) begin bad++; $display("FAIL stop_row_read col=%0d got=%h want=%h", a, v, expv); end
        end
      end
      for (int i = 0; i < 5; i++) begin dack = 1'b1; tick(); hi += int'(drq); end
      dack = 1'b0;
    end
    total++; if (hi != 0) begin bad++; $display("FAIL stop_drq high_cycles=%0d want=0", hi); end
    total++; if (stopped !== 1'b1) begin bad++; $display("FAIL stopped_persist got=%b want=1", stopped); end
    total++; if (underrun !== 1'b0) begin bad++; $display("FAIL stop_underrun got=%b want=0", underrun); end
    read_col(0, v);
    total++; if (v !== 8'h00) begin bad++; $display("FAIL stop_blank_read got=%h want=00", v); end
    pulse_frame();
    total++; if (drq !== 1'b1) begin bad++; $display("FAIL restart_drq got=%b want=1", drq); end
    total++; if (stopped !== 1'b0) begin bad++; $display("FAIL restart_stopped got=%b want=0", stopped); end
  endtask

  task automatic test_enable();
    max_col = AW'(9); burst_len = 2'd0; burst_gap = 3'd0;
    pulse_frame();
    total++; if (drq !== 1'b1) begin bad++; $display("FAIL en_start_drq got=%b want=1", drq); end
    enable = 1'b0;
    tick();
    total++; if (drq !== 1'b0) begin bad++; $display("FAIL disable_drq got=%b want=0", drq); end
    enable = 1'b1;
    repeat (3) tick();
    total++; if (drq !== 1'b0) begin bad++; $display("FAIL reenable_wait_drq got=%b want=0", drq); end
    pulse_swap();
    total++; if (drq !== 1'b1) begin bad++; $display("FAIL reenable_swap_drq got=%b want=1", drq); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] x, v, expv;
    pulse_clr();
    max_col = AW'(9); burst_len = 2'd3; burst_gap = 3'd0;
    src_q.delete();
    for (int i = 0; i < 10; i++) src_q.push_back(rnd_byte());
    pulse_frame();
    dma_run(2, 100, 100, 0);
    total++; if (drq !== 1'b1) begin bad++; $display("FAIL mid_burst_drq got=%b want=1", drq); end
    x = rnd_byte();
    dack = 1'b1; ichar = x; row_swap = 1'b1;
    tick();
    dack = 1'b0; row_swap = 1'b0;
    total++; if (underrun !== 1'b1) begin bad++; $display("FAIL swap_dack_underrun got=%b want=1", underrun); end
    for (int a = 0; a < 4; a++) begin
      read_col(a, v);
      expv = (a < 2) ? src_q[a] : ((a == 2) ? x : 8'h00);
      total++; if (v !== expv) begin bad++; $display("FAIL swap_dack_read col=%0d got=%h want=%h", a, v, expv); end
    end
  endtask

  task automatic test_reset_mid_burst();
    pulse_frame();
    total++; if (drq !== 1'b1) begin bad++; $display("FAIL pre_reset_drq got=%b want=1", drq); end
    dack = 1'b1; ichar = rnd_byte();
    #2 reset_n = 1'b0;
    #1;
    total++; if (drq !== 1'b0) begin bad++; $display("FAIL async_reset_drq got=%b want=0", drq); end
    total++; if (underrun !== 1'b0) begin bad++; $display("FAIL async_reset_underrun got=%b want=0", underrun); end
    total++; if (rd_data !== 8'h00) begin bad++; $display("FAIL async_reset_rd_data got=%h want=00", rd_data); end
    tick();
    reset_n = 1'b1;
    tick();
    dack = 1'b0;
    total++; if (drq !== 1'b0) begin bad++; $display("FAIL post_reset_drq got=%b want=0", drq); end
  endtask

  initial begin
    test_reset();
    test_burst_gap();
    test_end_row();
    test_underrun();
    test_end_screen();
    test_enable();
    test_back_to_back();
    test_reset_mid_burst();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
